// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential HI/LO multiply/divide unit:
// op encodings, FSM states and the two's-complement helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Widest vector neg2c handles; callers zero-extend and truncate back.
  localparam int NEG_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic logic [NEG_MAX_W-1:0] neg2c(input logic [NEG_MAX_W-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for sign-correcting the product, quotient and remainder.
module muldiv_negate
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? WIDTH'(neg2c(NEG_MAX_W'(x))) : x;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle HI/LO multiply/divide: shift-add multiply and restoring
// divide on magnitudes, one bit per clock, with start/busy/done handshake.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           op_r;
  logic                 sa, sb, zdiv;
  logic [WIDTH-1:0]     ma, mb, ra;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH:0]       add_sum, sub_diff;

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (
    .neg(op[0] & da[WIDTH-1]), .x(da), .y(abs_a));
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (
    .neg(op[0] & db[WIDTH-1]), .x(db), .y(abs_b));

  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg((op_r == OP_MULT) & (sa ^ sb)), .x(acc), .y(prod_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .neg((op_r == OP_DIV) & (sa ^ sb)), .x(acc[WIDTH-1:0]), .y(quo_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .neg((op_r == OP_DIV) & sa), .x(acc[2*WIDTH-1:WIDTH]), .y(rem_fix));

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? ma : '0)};
    sub_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
    acc_next = acc;
    if (op_r[1]) begin
      if (sub_diff[WIDTH])
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_next = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

  // Datapath registers: loaded at start, iterated during CALC.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_r <= op;
      sa   <= op[0] & da[WIDTH-1];
      sb   <= op[0] & db[WIDTH-1];
      ma   <= abs_a;
      mb   <= abs_b;
      ra   <= da;
      zdiv <= op[1] & (db == '0);
      acc  <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
    end else if (state == CALC) begin
      acc  <= acc_next;
    end
  end

  // Control FSM and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            cnt   <= CNT_W'(WIDTH - 1);
            busy  <= 1'b1;
            dbz   <= 1'b0;
          end else begin
            if (mthi) hi <= da;
            if (mtlo) lo <= da;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (zdiv) begin
            hi  <= ra;
            lo  <= '1;
            dbz <= 1'b1;
          end else if (op_r[1]) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq (WIDTH=32): expected results are queued
// at launch and compared when done pulses.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] da, db;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t_start;
  logic [64:0] sb_q[$];

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .da(da), .db(db),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .dbz(dbz),
    .hi(hi), .lo(lo));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [63:0]        up;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb, q, r;
    case (o)
      2'b00: begin
        up = {32'b0, a} * {32'b0, b};
        return {1'b0, up};
      end
      2'b01: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return {1'b0, sp};
      end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {1'b0, 32'h0, 32'h8000_0000};
        sa = a; sb = b;
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; da = a; db = b; start = 1'b1;
    sb_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    t_start = cyc;
    da = $urandom; db = $urandom;
    check("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string tag);
    logic [64:0] e;
    bit seen = 0;
    for (int i = 0; i < W + 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
      else if (busy !== 1'b1) begin
        check({tag, "_busy_early_drop"}, {63'b0, busy}, 64'd1);
      end
    end
    check({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
    if (seen) begin
      e = sb_q.pop_front();
      check({tag, "_latency"}, 64'(cyc - t_start), 64'(W + 1));
      check({tag, "_hi"}, {32'b0, hi}, {32'b0, e[63:32]});
      check({tag, "_lo"}, {32'b0, lo}, {32'b0, e[31:0]});
      check({tag, "_dbz"}, {63'b0, dbz}, {63'b0, e[64]});
      check({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
    end else if (sb_q.size() != 0) begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int ndone;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; da = '0; db = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_dbz", {63'b0, dbz}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0002); wait_done("multu");
    launch(2'b01, 32'hFFFF_FFFD, 32'h0000_0005); wait_done("mult_neg");
    launch(2'b11, 32'hFFFF_FFF9, 32'h0000_0002); wait_done("div_neg");
    launch(2'b10, 32'h0000_000A, 32'h0000_0000); wait_done("divu_dbz");
    launch(2'b00, 32'h0000_0003, 32'h0000_0004);
    check("dbz_cleared", {63'b0, dbz}, 64'd0);
    wait_done("multu_small");
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_min");
    launch(2'b11, 32'h0000_0007, 32'h0000_0000); wait_done("div_dbz");
    launch(2'b11, 32'h0000_0007, 32'hFFFF_FFFE); wait_done("div_pos_neg");

    // start + mthi while busy must not disturb the running op
    launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    repeat (5) @(posedge clk);
    #1;
    op = 2'b00; da = 32'h1234_5678; start = 1'b1; mthi = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("busy_hi_untouched", {63'b0, hi == 32'h1234_5678}, 64'd0);
    wait_done("conflict");
    check("hi_not_mthi", {63'b0, hi == 32'h1234_5678}, 64'd0);

    // IDLE moves
    da = 32'hCAFE_BABE; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo", {32'b0, lo}, {32'b0, 32'hCAFE_BABE});
    da = 32'h1111_2222; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("both_hi", {32'b0, hi}, {32'b0, 32'h1111_2222});
    check("both_lo", {32'b0, lo}, {32'b0, 32'h1111_2222});
    mthi = 1'b1;
    launch(2'b00, 32'h0000_0005, 32'h0000_0006);
    mthi = 1'b0;
    check("start_wins_hi", {32'b0, hi}, {32'b0, 32'h1111_2222});
    wait_done("start_wins");

    // reset mid-operation aborts without a done pulse
    launch(2'b10, 32'h0000_0064, 32'h0000_0007);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    void'(sb_q.pop_front());
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    launch(2'b10, 32'h0000_0064, 32'h0000_0007); wait_done("after_abort");

    for (int k = 0; k < 8; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (k % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (k == 3) ra = 32'h8000_0001;
      launch(ro, ra, rb);
      wait_done("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
